// File: rtl/vm_pkg.sv
// Shared types, coin values and the price table for the vending-machine front end.
package vm_pkg;

    localparam int unsigned CREDIT_W    = 8;
    localparam int unsigned ITEM_W      = 8;
    localparam int unsigned PRICE_ITEMS = 8;

    localparam logic [ITEM_W-1:0] VM_REFUND_ITEM = 8'h00;

    typedef enum logic [1:0] {
        COIN_5C   = 2'd0,
        COIN_10C  = 2'd1,
        COIN_25C  = 2'd2,
        COIN_100C = 2'd3
    } coin_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_VEND    = 2'd2,
        ST_REFUND  = 2'd3
    } state_e;

    // Record handed to the downstream packer: item -> input_1, change -> input_2.
    typedef struct packed {
        logic [ITEM_W-1:0]   item;
        logic [CREDIT_W-1:0] change;
    } vend_rec_t;

    // Price in cents of items 1..8.
    localparam logic [CREDIT_W-1:0] PRICE [1:PRICE_ITEMS] = '{
        8'd50, 8'd65, 8'd75, 8'd100, 8'd125, 8'd150, 8'd35, 8'd200
    };

    // Face value of a coin in cents.
    function automatic logic [CREDIT_W-1:0] coin_value(input coin_e c);
        case (c)
            COIN_5C:  return 8'd5;
            COIN_10C: return 8'd10;
            COIN_25C: return 8'd25;
            default:  return 8'd100;
        endcase
    endfunction

endpackage

// File: rtl/vm_price_lookup.sv
// Combinational item-code -> price lookup with a legality flag (codes 1..NUM_ITEMS).
module vm_price_lookup
    import vm_pkg::*;
#(
    parameter int unsigned NUM_ITEMS = 8
) (
    input  logic [7:0] item,
    output logic [7:0] price,
    output logic       item_legal
);

    // Scan the table; codes outside 1..NUM_ITEMS or beyond the table stay illegal.
    always_comb begin
        price      = '0;
        item_legal = 1'b0;
        for (int unsigned i = 1; i <= PRICE_ITEMS; i++) begin
            if (i <= NUM_ITEMS && item == ITEM_W'(i)) begin
                price      = PRICE[i];
                item_legal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vm_credit_ctrl.sv
// Coin/credit controller: accumulates credit, validates selections and issues one
// vend or refund record per purchase over a valid/ready handshake.
module vm_credit_ctrl
    import vm_pkg::*;
#(
    parameter int unsigned MAX_CREDIT = 250,
    parameter int unsigned NUM_ITEMS  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    output logic       coin_accept,
    output logic       coin_reject,
    input  logic       sel_valid,
    input  logic [7:0] sel_item,
    output logic       sel_reject,
    input  logic       cancel,
    output logic [7:0] credit,
    output logic       vend_valid,
    input  logic       vend_ready,
    output logic [7:0] vend_item,
    output logic [7:0] vend_change
);

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    vend_rec_t           vend_q, vend_d;
    logic                vend_valid_q, vend_valid_d;
    logic                coin_accept_q, coin_accept_d;
    logic                coin_reject_q, coin_reject_d;
    logic                sel_reject_q, sel_reject_d;

    logic [CREDIT_W-1:0] price;
    logic                item_legal;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_fits;

    vm_price_lookup #(
        .NUM_ITEMS (NUM_ITEMS)
    ) u_price (
        .item       (sel_item),
        .price      (price),
        .item_legal (item_legal)
    );

    // Next-state, credit and output-register logic; cancel > coin > select.
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        vend_d        = vend_q;
        vend_valid_d  = vend_valid_q;
        coin_accept_d = 1'b0;
        coin_reject_d = 1'b0;
        sel_reject_d  = 1'b0;

        // One extra bit so an overflowing sum never wraps below the ceiling.
        coin_sum  = {1'b0, credit_q} + {1'b0, coin_value(coin_e'(coin_type))};
        coin_fits = (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));

        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                if (cancel && credit_q != '0) begin
                    coin_reject_d = coin_valid;
                    vend_d.item   = VM_REFUND_ITEM;
                    vend_d.change = credit_q;
                    vend_valid_d  = 1'b1;
                    credit_d      = '0;
                    state_d       = ST_REFUND;
                end else if (coin_valid) begin
                    if (coin_fits) begin
                        coin_accept_d = 1'b1;
                        credit_d      = coin_sum[CREDIT_W-1:0];
                        state_d       = ST_COLLECT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                    sel_reject_d = sel_valid;
                end else if (sel_valid) begin
                    if (item_legal && credit_q >= price) begin
                        vend_d.item   = sel_item;
                        vend_d.change = credit_q - price;
                        vend_valid_d  = 1'b1;
                        credit_d      = '0;
                        state_d       = ST_VEND;
                    end else begin
                        sel_reject_d = 1'b1;
                    end
                end
            end
            ST_VEND, ST_REFUND: begin
                coin_reject_d = coin_valid;
                if (vend_ready) begin
                    vend_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            credit_q      <= '0;
            vend_q        <= '0;
            vend_valid_q  <= 1'b0;
            coin_accept_q <= 1'b0;
            coin_reject_q <= 1'b0;
            sel_reject_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            vend_q        <= vend_d;
            vend_valid_q  <= vend_valid_d;
            coin_accept_q <= coin_accept_d;
            coin_reject_q <= coin_reject_d;
            sel_reject_q  <= sel_reject_d;
        end
    end

    assign credit      = credit_q;
    assign vend_valid  = vend_valid_q;
    assign vend_item   = vend_q.item;
    assign vend_change = vend_q.change;
    assign coin_accept = coin_accept_q;
    assign coin_reject = coin_reject_q;
    assign sel_reject  = sel_reject_q;

endmodule
